// File: rtl/ex_mdu.sv
// Execute stage: single-cycle RV32I ALU/branch unit with an iterative RV32M multiply/divide.
// M-ops stall the front end via hold_flag_o and are written back once, in the DONE state.
module ex_mdu #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned M_EXT        = 1,
  parameter int unsigned BITS_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_write_en,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_flag_o
);

  localparam int unsigned N    = XLEN / BITS_PER_CYC;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ShW  = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  // Decode
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       is_op, is_opimm, is_branch, is_m_op;

  assign opcode    = inst_i[6:0];
  assign func3     = inst_i[14:12];
  assign func7     = inst_i[31:25];
  assign is_op     = (opcode == 7'b0110011);
  assign is_opimm  = (opcode == 7'b0010011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_m_op   = (M_EXT != 0) && is_op && (func7 == 7'b0000001);

  logic unused_rs;
  assign unused_rs = ^inst_i[24:15];

  // Single-cycle ALU
  logic [ShW-1:0]  shamt;
  logic            lt_s, lt_u;
  logic [XLEN-1:0] alu_res;
  logic            alu_ok;

  assign shamt = op2_i[ShW-1:0];
  assign lt_s  = $signed(op1_i) < $signed(op2_i);
  assign lt_u  = op1_i < op2_i;

  always_comb begin
    alu_ok  = 1'b0;
    alu_res = '0;
    if (is_op && func7 == 7'b0000000) begin
      alu_ok = 1'b1;
      unique case (func3)
        3'b000:  alu_res = op1_i + op2_i;
        3'b001:  alu_res = op1_i << shamt;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
        3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
        3'b100:  alu_res = op1_i ^ op2_i;
        3'b101:  alu_res = op1_i >> shamt;
        3'b110:  alu_res = op1_i | op2_i;
        default: alu_res = op1_i & op2_i;
      endcase
    end else if (is_op && func7 == 7'b0100000) begin
      if (func3 == 3'b000) begin
        alu_ok  = 1'b1;
        alu_res = op1_i - op2_i;
      end else if (func3 == 3'b101) begin
        alu_ok  = 1'b1;
        alu_res = $signed(op1_i) >>> shamt;
      end
    end else if (is_opimm) begin
      unique case (func3)
        3'b000: begin alu_ok = 1'b1; alu_res = op1_i + op2_i; end
        3'b010: begin alu_ok = 1'b1; alu_res = {{(XLEN-1){1'b0}}, lt_s}; end
        3'b011: begin alu_ok = 1'b1; alu_res = {{(XLEN-1){1'b0}}, lt_u}; end
        3'b100: begin alu_ok = 1'b1; alu_res = op1_i ^ op2_i; end
        3'b110: begin alu_ok = 1'b1; alu_res = op1_i | op2_i; end
        3'b111: begin alu_ok = 1'b1; alu_res = op1_i & op2_i; end
        3'b001: begin
          alu_ok  = (func7 == 7'b0000000);
          alu_res = op1_i << shamt;
        end
        default: begin
          if (func7 == 7'b0000000) begin
            alu_ok  = 1'b1;
            alu_res = op1_i >> shamt;
          end else if (func7 == 7'b0100000) begin
            alu_ok  = 1'b1;
            alu_res = $signed(op1_i) >>> shamt;
          end
        end
      endcase
    end
  end

  // Branch compare and target
  logic [12:0]      b_imm;
  logic [XLEN+12:0] b_ext;
  logic [XLEN-1:0]  br_target;
  logic             br_ok, br_taken;

  assign b_imm     = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign b_ext     = {{XLEN{b_imm[12]}}, b_imm};
  assign br_target = inst_addr_i + b_ext[XLEN-1:0];

  always_comb begin
    br_ok    = 1'b1;
    br_taken = 1'b0;
    unique case (func3)
      3'b000:  br_taken = (op1_i == op2_i);
      3'b001:  br_taken = (op1_i != op2_i);
      3'b100:  br_taken = lt_s;
      3'b101:  br_taken = !lt_s;
      3'b110:  br_taken = lt_u;
      3'b111:  br_taken = !lt_u;
      default: br_ok    = 1'b0;
    endcase
  end

  // Operand conditioning for the M unit: work on magnitudes, fix signs at the end
  logic            sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            neg_q_in;

  assign sgn1     = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) ||
                    (func3 == 3'b110);
  assign sgn2     = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
  assign s1       = sgn1 && op1_i[XLEN-1];
  assign s2       = sgn2 && op2_i[XLEN-1];
  assign mag1     = s1 ? -op1_i : op1_i;
  assign mag2     = s2 ? -op2_i : op2_i;
  // Divide by zero keeps the all-ones quotient un-negated
  assign neg_q_in = (s1 ^ s2) && !(func3[2] && op2_i == '0);

  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [XLEN-1:0]   b_q;
  logic [CntW-1:0]   cnt_q;
  logic [4:0]        rd_q;
  logic [2:0]        func3_q;
  logic              neg_q_q, neg_r_q;
  logic              cnt_last;

  assign cnt_last = (cnt_q == CntW'(N - 1));

  // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic [XLEN:0] rem_sh, diff, sum;

  always_comb begin
    acc_nxt = acc_q;
    rem_sh  = '0;
    diff    = '0;
    sum     = '0;
    for (int k = 0; k < int'(BITS_PER_CYC); k++) begin
      if (func3_q[2]) begin
        rem_sh = {acc_nxt[2*XLEN-1:XLEN], acc_nxt[XLEN-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (!diff[XLEN]) begin
          acc_nxt = {diff[XLEN-1:0], acc_nxt[XLEN-2:0], 1'b1};
        end else begin
          acc_nxt = {rem_sh[XLEN-1:0], acc_nxt[XLEN-2:0], 1'b0};
        end
      end else begin
        sum     = {1'b0, acc_nxt[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_nxt[0]}} & {1'b0, b_q});
        acc_nxt = {sum, acc_nxt[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      func3_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (state_q == StIdle && is_m_op) begin
      acc_q   <= {{XLEN{1'b0}}, mag1};
      b_q     <= mag2;
      cnt_q   <= '0;
      rd_q    <= rd_addr_i;
      func3_q <= func3;
      neg_q_q <= neg_q_in;
      neg_r_q <= s1;
    end else if (state_q == StBusy) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Final sign fix and result select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, m_res;

  assign prod = neg_q_q ? -acc_q : acc_q;
  assign quo  = neg_q_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    if (!func3_q[2]) begin
      m_res = (func3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      m_res = func3_q[1] ? rem : quo;
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (is_m_op) state_d = StBusy;
      StBusy:  if (cnt_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_write_en = 1'b0;
    jump_addr_o = '0;
    jump_en_o   = 1'b0;
    hold_flag_o = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (is_m_op) begin
            hold_flag_o = 1'b1;
          end else if (alu_ok) begin
            rd_addr_o   = rd_addr_i;
            rd_data_o   = alu_res;
            rd_write_en = (rd_addr_i != 5'd0);
          end else if (is_branch && br_ok) begin
            jump_addr_o = br_target;
            jump_en_o   = br_taken;
          end
        end
        StBusy: hold_flag_o = 1'b1;
        StDone: begin
          rd_addr_o   = rd_q;
          rd_data_o   = m_res;
          rd_write_en = (rd_q != 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: ALU, branches, illegal decode, M-op latency/results,
// reset mid-operation, back-to-back ops, and an M_EXT=0 instance alongside.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, op1, op2;
  logic [4:0]  rd;

  logic [4:0]  rd_addr_o, z_rd_addr;
  logic [31:0] rd_data_o, z_rd_data, jump_addr_o, z_jaddr;
  logic        rd_write_en, jump_en_o, hold_flag_o, z_we, z_jen, z_hold;

  logic [71:0] d_all, z_all;
  assign d_all = {rd_addr_o, rd_data_o, rd_write_en, jump_addr_o, jump_en_o, hold_flag_o};
  assign z_all = {z_rd_addr, z_rd_data, z_we, z_jaddr, z_jen, z_hold};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mdu #(.XLEN(32), .M_EXT(1), .BITS_PER_CYC(1)) dut (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(pc), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_write_en(rd_write_en),
    .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o), .hold_flag_o(hold_flag_o)
  );

  ex_mdu #(.XLEN(32), .M_EXT(0), .BITS_PER_CYC(1)) dut0 (
    .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(pc), .op1_i(op1), .op2_i(op2),
    .rd_addr_i(rd), .rd_addr_o(z_rd_addr), .rd_data_o(z_rd_data), .rd_write_en(z_we),
    .jump_addr_o(z_jaddr), .jump_en_o(z_jen), .hold_flag_o(z_hold)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rdi);
    return {f7, 5'd2, 5'd1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rdi);
    return {imm, 5'd1, f3, rdi, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_reset();
    rst = 1'b1; pc = 32'h100; op1 = 32'd5; op2 = 32'd7; rd = 5'd3;
    inst = enc_r(7'h00, 3'b000, 5'd3);
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (d_all !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want 0", d_all);
    end
    inst = enc_r(7'h01, 3'b000, 5'd3);
    #1;
    n_vec++;
    if (hold_flag_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mop_hold: got %b, want 0", hold_flag_o);
    end
    @(negedge clk);
    rst = 1'b0; inst = 32'h0;
    #1;
    n_vec++;
    if (d_all !== '0) begin
      n_err++;
      $display("FAIL reset_release_idle: got %h, want 0", d_all);
    end
  endtask

  task automatic test_alu();
    vec_t v[14];
    v[0]  = '{"add",   enc_r(7'h00, 3'b000, 5'd3), 32'd5,        32'd7,        32'd12};
    v[1]  = '{"sub",   enc_r(7'h20, 3'b000, 5'd3), 32'd5,        32'd7,        32'hFFFF_FFFE};
    v[2]  = '{"sll",   enc_r(7'h00, 3'b001, 5'd3), 32'd1,        32'h24,       32'h10};
    v[3]  = '{"slt",   enc_r(7'h00, 3'b010, 5'd3), 32'hFFFF_FFFF, 32'd1,       32'd1};
    v[4]  = '{"sltu",  enc_r(7'h00, 3'b011, 5'd3), 32'hFFFF_FFFF, 32'd1,       32'd0};
    v[5]  = '{"xor",   enc_r(7'h00, 3'b100, 5'd3), 32'hF0F0,     32'hFF00,     32'h0FF0};
    v[6]  = '{"srl",   enc_r(7'h00, 3'b101, 5'd3), 32'h8000_0000, 32'd4,       32'h0800_0000};
    v[7]  = '{"sra",   enc_r(7'h20, 3'b101, 5'd3), 32'h8000_0000, 32'd4,       32'hF800_0000};
    v[8]  = '{"or",    enc_r(7'h00, 3'b110, 5'd3), 32'hF0,       32'h0F,       32'hFF};
    v[9]  = '{"and",   enc_r(7'h00, 3'b111, 5'd3), 32'hF0,       32'h3C,       32'h30};
    v[10] = '{"addi",  enc_i(12'hFFF, 3'b000, 5'd3), 32'd10,     32'hFFFF_FFFF, 32'd9};
    v[11] = '{"srai",  enc_i(12'h404, 3'b101, 5'd3), 32'h8000_0000, 32'h404,   32'hF800_0000};
    v[12] = '{"sltiu", enc_i(12'hFFF, 3'b011, 5'd3), 32'd5,      32'hFFFF_FFFF, 32'd1};
    v[13] = '{"slli",  enc_i(12'h003, 3'b001, 5'd3), 32'd3,      32'd3,        32'h18};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      inst = v[i].ins; op1 = v[i].a; op2 = v[i].b; rd = 5'd3;
      #1;
      n_vec++;
      if (rd_data_o !== v[i].exp || rd_write_en !== 1'b1 || rd_addr_o !== 5'd3 ||
          hold_flag_o !== 1'b0 || jump_en_o !== 1'b0) begin
        n_err++;
        $display("FAIL alu_%s: data=%h we=%b rd=%0d hold=%b jmp=%b, want data=%h we=1 rd=3 hold=0",
                 v[i].name, rd_data_o, rd_write_en, rd_addr_o, hold_flag_o, jump_en_o, v[i].exp);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[6];
    logic [5:0] taken;
    v[0] = '{"blt",  enc_b(13'h1FF8, 3'b100), 32'hFFFF_FFFF, 32'd1, 32'hF8};
    v[1] = '{"bltu", enc_b(13'h1FF8, 3'b110), 32'hFFFF_FFFF, 32'd1, 32'hF8};
    v[2] = '{"beq",  enc_b(13'h0010, 3'b000), 32'd5,         32'd5, 32'h110};
    v[3] = '{"bne",  enc_b(13'h0010, 3'b001), 32'd5,         32'd5, 32'h110};
    v[4] = '{"bge",  enc_b(13'h1FF8, 3'b101), 32'hFFFF_FFFF, 32'd1, 32'hF8};
    v[5] = '{"bgeu", enc_b(13'h0010, 3'b111), 32'hFFFF_FFFF, 32'd1, 32'h110};
    taken = 6'b100101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      inst = v[i].ins; op1 = v[i].a; op2 = v[i].b; rd = 5'd7; pc = 32'h100;
      #1;
      n_vec++;
      if (jump_en_o !== taken[i] || jump_addr_o !== v[i].exp || rd_write_en !== 1'b0 ||
          hold_flag_o !== 1'b0) begin
        n_err++;
        $display("FAIL br_%s: en=%b addr=%h we=%b hold=%b, want en=%b addr=%h we=0 hold=0",
                 v[i].name, jump_en_o, jump_addr_o, rd_write_en, hold_flag_o, taken[i], v[i].exp);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad[4];
    bad[0] = enc_r(7'h20, 3'b001, 5'd3);
    bad[1] = 32'h0000_0000;
    bad[2] = enc_b(13'h0010, 3'b010);
    bad[3] = enc_i(12'h403, 3'b001, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst = bad[i]; op1 = 32'd5; op2 = 32'd5; rd = 5'd3;
      #1;
      n_vec++;
      if (d_all !== '0) begin
        n_err++;
        $display("FAIL illegal_%0d: outputs=%h, want 0", i, d_all);
      end
    end
    @(negedge clk);
    inst = enc_r(7'h00, 3'b000, 5'd0); op1 = 32'd5; op2 = 32'd7; rd = 5'd0;
    #1;
    n_vec++;
    if (rd_write_en !== 1'b0) begin
      n_err++;
      $display("FAIL add_x0: we=%b, want 0", rd_write_en);
    end
  endtask

  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rdi, input logic [31:0] exp);
    int cyc;
    bit early_we;
    bit z_bad;
    @(negedge clk);
    inst = enc_r(7'h01, f3, rdi); op1 = a; op2 = b; rd = rdi;
    #1;
    n_vec++;
    if (hold_flag_o !== 1'b1 || rd_write_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_accept: hold=%b we=%b, want hold=1 we=0", name, hold_flag_o, rd_write_en);
    end
    cyc = 1; early_we = 1'b0; z_bad = 1'b0;
    while (hold_flag_o === 1'b1 && cyc < 40) begin
      if (rd_write_en !== 1'b0 || jump_en_o !== 1'b0) early_we = 1'b1;
      if (z_all !== '0) z_bad = 1'b1;
      @(posedge clk);
      #1;
      if (hold_flag_o === 1'b1) cyc++;
    end
    n_vec++;
    if (cyc != 33 || early_we) begin
      n_err++;
      $display("FAIL %s_latency: hold cycles=%0d early_write=%b, want 33 and 0",
               name, cyc, early_we);
    end
    n_vec++;
    if (rd_write_en !== (rdi != 5'd0) || rd_addr_o !== rdi || hold_flag_o !== 1'b0 ||
        jump_en_o !== 1'b0 || (rdi != 5'd0 && rd_data_o !== exp)) begin
      n_err++;
      $display("FAIL %s_result: data=%h we=%b rd=%0d hold=%b, want data=%h we=%b rd=%0d hold=0",
               name, rd_data_o, rd_write_en, rd_addr_o, hold_flag_o, exp, rdi != 5'd0, rdi);
    end
    n_vec++;
    if (z_bad || z_all !== '0) begin
      n_err++;
      $display("FAIL %s_mext0: outputs=%h seen_nonzero=%b, want 0", name, z_all, z_bad);
    end
    @(negedge clk);
    inst = 32'h0;
    @(posedge clk);
    #1;
    n_vec++;
    if (rd_write_en !== 1'b0 || hold_flag_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_single_write: we=%b hold=%b, want 0 0", name, rd_write_en, hold_flag_o);
    end
  endtask

  task automatic test_mul();
    run_mop("mulh",   3'b001, 32'h8000_0000, 32'd2,         5'd3, 32'hFFFF_FFFF);
    run_mop("mul",    3'b000, 32'h8000_0000, 32'd2,         5'd3, 32'h0);
    run_mop("mul_neg", 3'b000, 32'd7,        32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB);
    run_mop("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
    run_mop("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
    run_mop("mulh_nn", 3'b001, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5'd7, 32'h0);
  endtask

  task automatic test_div();
    run_mop("div_by0",  3'b100, 32'd7,         32'd0,         5'd3, 32'hFFFF_FFFF);
    run_mop("rem_by0",  3'b110, 32'd7,         32'd0,         5'd3, 32'd7);
    run_mop("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000);
    run_mop("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h0);
    run_mop("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd8, 32'hFFFF_FFFD);
    run_mop("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8, 32'hFFFF_FFFF);
    run_mop("divu",     3'b101, 32'hFFFF_FFFF, 32'd16,        5'd9, 32'h0FFF_FFFF);
    run_mop("remu",     3'b111, 32'd100,       32'd7,         5'd9, 32'd2);
    run_mop("div_nby0", 3'b100, 32'hFFFF_FFF9, 32'd0,         5'd9, 32'hFFFF_FFFF);
    run_mop("rem_nby0", 3'b110, 32'hFFFF_FFF9, 32'd0,         5'd9, 32'hFFFF_FFF9);
  endtask

  task automatic test_rd_zero();
    run_mop("mul_x0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42);
  endtask

  task automatic test_mid_reset();
    bit saw_we;
    @(negedge clk);
    inst = enc_r(7'h01, 3'b100, 5'd5); op1 = 32'd100; op2 = 32'd7; rd = 5'd5;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (hold_flag_o !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_busy: hold=%b, want 1", hold_flag_o);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    saw_we = (rd_write_en !== 1'b0);
    n_vec++;
    if (d_all !== '0) begin
      n_err++;
      $display("FAIL midrst_during: outputs=%h, want 0", d_all);
    end
    @(posedge clk);
    #1;
    if (rd_write_en !== 1'b0) saw_we = 1'b1;
    n_vec++;
    if (hold_flag_o !== 1'b0 || saw_we) begin
      n_err++;
      $display("FAIL midrst_after: hold=%b write_seen=%b, want 0 0", hold_flag_o, saw_we);
    end
    @(negedge clk);
    rst = 1'b0; inst = enc_r(7'h00, 3'b000, 5'd3); op1 = 32'd5; op2 = 32'd7; rd = 5'd3;
    #1;
    n_vec++;
    if (rd_data_o !== 32'd12 || rd_write_en !== 1'b1 || hold_flag_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_add: data=%h we=%b hold=%b, want 0000000c 1 0",
               rd_data_o, rd_write_en, hold_flag_o);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (rd_data_o !== 32'd12 || hold_flag_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_idle: data=%h hold=%b, want 0000000c 0", rd_data_o, hold_flag_o);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    inst = enc_r(7'h01, 3'b000, 5'd4); op1 = 32'd6; op2 = 32'd7; rd = 5'd4;
    #1;
    cyc = 0;
    while (hold_flag_o === 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++;
    if (rd_write_en !== 1'b1 || rd_data_o !== 32'd42 || rd_addr_o !== 5'd4) begin
      n_err++;
      $display("FAIL b2b_mul: data=%h we=%b rd=%0d, want 0000002a 1 4",
               rd_data_o, rd_write_en, rd_addr_o);
    end
    // New instruction shows up during DONE; the latched result must still be presented
    @(negedge clk);
    inst = enc_r(7'h00, 3'b000, 5'd3); op1 = 32'd5; op2 = 32'd7; rd = 5'd3;
    #1;
    n_vec++;
    if (rd_data_o !== 32'd42 || rd_addr_o !== 5'd4 || rd_write_en !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done_nodecode: data=%h rd=%0d we=%b, want 0000002a 4 1",
               rd_data_o, rd_addr_o, rd_write_en);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (rd_data_o !== 32'd12 || rd_addr_o !== 5'd3 || rd_write_en !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_add: data=%h rd=%0d we=%b, want 0000000c 3 1",
               rd_data_o, rd_addr_o, rd_write_en);
    end
    run_mop("b2b_divu", 3'b101, 32'd42, 32'd5, 5'd6, 32'd8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_illegal();
    test_mul();
    test_div();
    test_rd_zero();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
